// File: rtl/ps2_host_fifo.sv
// ps2_host_fifo: buffered PS/2 host transceiver with a show-ahead RX FIFO,
// a valid/ready command path with inhibit/timeout, and optional auto-init.
module ps2_host_fifo #(
  parameter int RX_DEPTH = 16,
  parameter int IDLE_CYCLES = 255,
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TX_TIMEOUT = 1000000,
  parameter int RX_BIT_TIMEOUT = 100000,
  parameter int INIT_ENABLE = 0,
  parameter logic [7:0] INIT_CMD = 8'hF4
) (
  input  logic CLOCK_50,
  input  logic reset,
  inout  wire  PS2_CLK,
  inout  wire  PS2_DAT,
  input  logic [7:0] cmd_data,
  input  logic cmd_valid,
  output logic cmd_ready,
  output logic cmd_done,
  output logic cmd_error,
  output logic [7:0] rx_data,
  output logic rx_valid,
  input  logic rx_ready,
  output logic [$clog2(RX_DEPTH):0] rx_count,
  output logic rx_overflow,
  output logic frame_error,
  output logic init_done
);
  localparam int AW = $clog2(RX_DEPTH);
  localparam int TMAX0 = TX_TIMEOUT > RX_BIT_TIMEOUT ? TX_TIMEOUT : RX_BIT_TIMEOUT;
  localparam int TMAX = TMAX0 > INHIBIT_CYCLES ? TMAX0 : INHIBIT_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(IDLE_CYCLES);
  localparam logic [TW-1:0] INH_LAST = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TX_LAST = TW'(TX_TIMEOUT - 1);
  localparam logic [TW-1:0] RX_TO = TW'(RX_BIT_TIMEOUT);
  localparam logic [AW:0] FULL = (AW + 1)'(RX_DEPTH);

  typedef enum logic [2:0] {IDLE, RX, TX_INHIBIT, TX_REQ, TX_BITS, TX_ACK} state_t;

  state_t state, state_n;
  logic [2:0] clk_sync;
  logic [1:0] dat_sync;
  logic [IW-1:0] idle_cnt, idle_n;
  logic [TW-1:0] timer, timer_n;
  logic [3:0] bit_cnt, bit_n;
  logic [8:0] sh, sh_n;
  logic clk_oe, clk_oe_n, dat_oe, dat_oe_n;
  logic done_n, err_n, ferr_n, push;
  logic clk_s, dat_s, fall, idle_sat, start;
  logic [7:0] tx_byte;

  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;
  assign clk_s = clk_sync[1];
  assign dat_s = dat_sync[1];
  assign fall = clk_sync[2] & ~clk_sync[1];
  assign idle_sat = idle_cnt == IDLE_MAX;
  assign tx_byte = init_done ? cmd_data : INIT_CMD;
  // Until init completes the internal command owns the transmitter.
  assign start = state == IDLE && idle_sat && !fall && (cmd_valid || !init_done);
  assign cmd_ready = state == IDLE && idle_sat && init_done && !fall;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_sync <= 3'b111;
      dat_sync <= 2'b11;
      state <= IDLE;
      idle_cnt <= '0;
      timer <= '0;
      bit_cnt <= '0;
      sh <= '0;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      cmd_done <= 1'b0;
      cmd_error <= 1'b0;
      frame_error <= 1'b0;
      init_done <= INIT_ENABLE == 0;
    end else begin
      clk_sync <= {clk_sync[1:0], PS2_CLK};
      dat_sync <= {dat_sync[0], PS2_DAT};
      state <= state_n;
      idle_cnt <= idle_n;
      timer <= timer_n;
      bit_cnt <= bit_n;
      sh <= sh_n;
      clk_oe <= clk_oe_n;
      dat_oe <= dat_oe_n;
      cmd_done <= done_n;
      cmd_error <= err_n;
      frame_error <= ferr_n;
      init_done <= init_done | done_n;
    end
  end

  always_comb begin
    state_n = state;
    idle_n = '0;
    timer_n = timer + 1'b1;
    bit_n = bit_cnt;
    sh_n = sh;
    clk_oe_n = clk_oe;
    dat_oe_n = dat_oe;
    done_n = 1'b0;
    err_n = 1'b0;
    ferr_n = 1'b0;
    push = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        idle_n = !clk_s ? '0 : idle_sat ? idle_cnt : idle_cnt + 1'b1;
        if (fall && !dat_s) begin
          state_n = RX;
          bit_n = 4'd1;
        end else if (start) begin
          state_n = TX_INHIBIT;
          sh_n = {~^tx_byte, tx_byte};
          clk_oe_n = 1'b1;
        end
      end
      RX: begin
        // Edges 2..10 shift d0..d7 and parity in; edge 11 is the stop bit.
        if (fall) begin
          timer_n = '0;
          bit_n = bit_cnt + 1'b1;
          if (bit_cnt == 4'd10) begin
            state_n = IDLE;
            push = dat_s & ^sh;
            ferr_n = ~push;
          end else sh_n = {dat_s, sh[8:1]};
        end else if (timer == RX_TO) begin
          state_n = IDLE;
          ferr_n = 1'b1;
        end
      end
      TX_INHIBIT: begin
        if (timer == INH_LAST) begin
          state_n = TX_REQ;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          timer_n = '0;
          bit_n = '0;
        end
      end
      TX_REQ, TX_BITS, TX_ACK: begin
        if (timer == TX_LAST) begin
          state_n = IDLE;
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b0;
          err_n = 1'b1;
        end else if (fall) begin
          if (state != TX_ACK && bit_cnt != 4'd9) begin
            state_n = TX_BITS;
            dat_oe_n = ~sh[0];
            sh_n = {1'b0, sh[8:1]};
            bit_n = bit_cnt + 1'b1;
          end else if (state == TX_BITS) begin
            state_n = TX_ACK;
            dat_oe_n = 1'b0;
          end else begin
            state_n = IDLE;
            done_n = ~dat_s;
            err_n = dat_s;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  logic [7:0] mem [RX_DEPTH];
  logic [AW-1:0] wp, rp;
  logic full, pop, wr;

  assign full = rx_count == FULL;
  assign rx_valid = rx_count != '0;
  assign rx_data = mem[rp];
  assign pop = rx_valid & rx_ready;
  // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
  assign wr = push & (~full | pop);

  always_ff @(posedge CLOCK_50) if (wr) mem[wp] <= sh[7:0];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      rx_count <= '0;
      rx_overflow <= 1'b0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(pop);
      rx_count <= rx_count + (AW + 1)'(wr) - (AW + 1)'(pop);
      rx_overflow <= rx_overflow | (push & full & ~pop);
    end
  end
endmodule

// File: tb/tb_ps2_host_fifo.sv
// tb_ps2_host_fifo: directed bench with a modelled PS/2 device on two DUT instances.
module tb_ps2_host_fifo;
  localparam int HALF = 20;
  localparam int TXT0 = 2000;

  logic CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  logic rst0, rst1, lclk0, ldat0, lclk1, ldat1;
  wire c0, d0, c1, d1;
  pullup (c0);
  pullup (d0);
  pullup (c1);
  pullup (d1);
  assign c0 = lclk0 ? 1'b0 : 1'bz;
  assign d0 = ldat0 ? 1'b0 : 1'bz;
  assign c1 = lclk1 ? 1'b0 : 1'bz;
  assign d1 = ldat1 ? 1'b0 : 1'bz;

  logic [7:0] cmd_data0, cmd_data1, rx_data0, rx_data1;
  logic cmd_valid0, cmd_valid1, cmd_ready0, cmd_ready1, cmd_done0, cmd_done1;
  logic cmd_error0, cmd_error1, rx_valid0, rx_valid1, rx_ready0, rx_ready1;
  logic rx_overflow0, rx_overflow1, frame_error0, frame_error1, init_done0, init_done1;
  logic [2:0] rx_count0;
  logic [4:0] rx_count1;

  ps2_host_fifo #(.RX_DEPTH(4), .TX_TIMEOUT(TXT0), .RX_BIT_TIMEOUT(1000)) dut0 (
    .CLOCK_50(CLOCK_50), .reset(rst0), .PS2_CLK(c0), .PS2_DAT(d0),
    .cmd_data(cmd_data0), .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0),
    .cmd_done(cmd_done0), .cmd_error(cmd_error0), .rx_data(rx_data0),
    .rx_valid(rx_valid0), .rx_ready(rx_ready0), .rx_count(rx_count0),
    .rx_overflow(rx_overflow0), .frame_error(frame_error0), .init_done(init_done0));

  ps2_host_fifo #(.INHIBIT_CYCLES(100), .TX_TIMEOUT(3000), .RX_BIT_TIMEOUT(1000),
    .INIT_ENABLE(1)) dut1 (
    .CLOCK_50(CLOCK_50), .reset(rst1), .PS2_CLK(c1), .PS2_DAT(d1),
    .cmd_data(cmd_data1), .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
    .cmd_done(cmd_done1), .cmd_error(cmd_error1), .rx_data(rx_data1),
    .rx_valid(rx_valid1), .rx_ready(rx_ready1), .rx_count(rx_count1),
    .rx_overflow(rx_overflow1), .frame_error(frame_error1), .init_done(init_done1));

  int checks = 0, failures = 0;
  int done0 = 0, err0 = 0, ferr0 = 0, done1 = 0, err1 = 0, early_ready1 = 0;

  always @(posedge CLOCK_50) begin
    if (cmd_done0) done0++;
    if (cmd_error0) err0++;
    if (frame_error0) ferr0++;
    if (cmd_done1) done1++;
    if (cmd_error1) err1++;
    if (!rst1 && cmd_ready1 && !init_done1) early_ready1++;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic set_clk(input int i, input logic v);
    if (i == 0) lclk0 = v; else lclk1 = v;
  endtask

  task automatic set_dat(input int i, input logic v);
    if (i == 0) ldat0 = v; else ldat1 = v;
  endtask

  function automatic logic bus_clk(input int i);
    return i == 0 ? c0 : c1;
  endfunction

  function automatic logic bus_dat(input int i);
    return i == 0 ? d0 : d1;
  endfunction

  task automatic send_byte(input int i, input logic [7:0] b, input logic bad_par,
                           input logic bad_stop, input logic pop_last);
    logic [10:0] f;
    f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int k = 0; k < 11; k++) begin
      set_dat(i, ~f[k]);
      tick(HALF);
      set_clk(i, 1'b1);
      if (k == 10 && pop_last) begin
        tick(2);
        rx_ready0 = 1'b1;
        tick(1);
        rx_ready0 = 1'b0;
        tick(HALF - 3);
      end else tick(HALF);
      set_clk(i, 1'b0);
    end
    set_dat(i, 1'b0);
    tick(HALF);
  endtask

  task automatic recv_cmd(input int i, input logic ack_low, output logic [7:0] b,
                          output logic par, output logic stp);
    logic [9:0] bits;
    int n;
    n = 0;
    while (!(bus_clk(i) === 1'b1 && bus_dat(i) === 1'b0) && n < 20000) begin
      tick(1);
      n++;
    end
    check("tx_request_seen", n < 20000, 1);
    for (int k = 0; k < 10; k++) begin
      tick(HALF);
      set_clk(i, 1'b1);
      tick(HALF);
      set_clk(i, 1'b0);
      tick(4);
      bits[k] = bus_dat(i);
    end
    tick(HALF);
    if (ack_low) set_dat(i, 1'b1);
    tick(2);
    set_clk(i, 1'b1);
    tick(HALF);
    set_clk(i, 1'b0);
    set_dat(i, 1'b0);
    tick(HALF);
    b = bits[7:0];
    par = bits[8];
    stp = bits[9];
  endtask

  task automatic issue_cmd0(input logic [7:0] b);
    int n;
    n = 0;
    cmd_data0 = b;
    cmd_valid0 = 1'b1;
    do begin
      @(negedge CLOCK_50);
      n++;
    end while (!cmd_ready0 && n < 5000);
    check("cmd_accept", n < 5000, 1);
    @(posedge CLOCK_50);
    #1 cmd_valid0 = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    logic p, s;
    logic [7:0] exp_q [4];
    int n;
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h66};
    rst0 = 1'b1; rst1 = 1'b1;
    lclk0 = 1'b0; ldat0 = 1'b0; lclk1 = 1'b0; ldat1 = 1'b0;
    cmd_data0 = '0; cmd_data1 = '0; cmd_valid0 = 1'b0; cmd_valid1 = 1'b0;
    rx_ready0 = 1'b0; rx_ready1 = 1'b0;
    tick(5);
    rst0 = 1'b0;
    tick(2);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_rx_count", rx_count0, 0);
    check("rst_cmd_ready", cmd_ready0, 0);
    check("rst_overflow", rx_overflow0, 0);
    check("rst_init_done", init_done0, 1);
    check("rst_clk_line", c0, 1);
    check("rst_dat_line", d0, 1);

    send_byte(0, 8'h1C, 1'b0, 1'b0, 1'b0);
    check("rx1_valid", rx_valid0, 1);
    check("rx1_data", rx_data0, 8'h1C);
    check("rx1_count", rx_count0, 1);
    check("rx1_no_ferr", ferr0, 0);
    rx_ready0 = 1'b1;
    tick(1);
    rx_ready0 = 1'b0;
    tick(1);
    check("pop_count", rx_count0, 0);
    check("pop_valid", rx_valid0, 0);

    send_byte(0, 8'h1C, 1'b1, 1'b0, 1'b0);
    check("badpar_ferr", ferr0, 1);
    check("badpar_count", rx_count0, 0);
    send_byte(0, 8'h55, 1'b0, 1'b1, 1'b0);
    check("badstop_ferr", ferr0, 2);
    check("badstop_count", rx_count0, 0);

    set_dat(0, 1'b1);
    tick(HALF);
    set_clk(0, 1'b1);
    tick(HALF);
    set_clk(0, 1'b0);
    set_dat(0, 1'b0);
    tick(1100);
    check("rx_timeout_ferr", ferr0, 3);
    check("rx_timeout_count", rx_count0, 0);

    issue_cmd0(8'hED);
    n = 0;
    while (c0 === 1'b0 && n < 10000) begin
      @(posedge CLOCK_50);
      #1 n++;
    end
    check("inhibit_cycles", n, 5000);
    recv_cmd(0, 1'b1, b, p, s);
    check("tx_byte_ED", b, 8'hED);
    check("tx_parity_ED", p, 1);
    check("tx_stop_ED", s, 1);
    tick(10);
    check("tx_done", done0, 1);
    check("tx_no_err", err0, 0);
    check("tx_no_rx", rx_count0, 0);

    issue_cmd0(8'hAA);
    n = 0;
    while (c0 === 1'b0 && n < 10000) begin
      @(posedge CLOCK_50);
      #1 n++;
    end
    n = 0;
    while (cmd_error0 !== 1'b1 && n < 5000) begin
      @(posedge CLOCK_50);
      #1 n++;
    end
    check("timeout_latency", n, TXT0);
    tick(2);
    check("timeout_err", err0, 1);
    check("timeout_done", done0, 1);
    check("timeout_clk_z", c0, 1);
    check("timeout_dat_z", d0, 1);

    send_byte(0, 8'h11, 1'b0, 1'b0, 1'b0);
    send_byte(0, 8'h22, 1'b0, 1'b0, 1'b0);
    send_byte(0, 8'h33, 1'b0, 1'b0, 1'b0);
    send_byte(0, 8'h44, 1'b0, 1'b0, 1'b0);
    check("fill_overflow0", rx_overflow0, 0);
    send_byte(0, 8'h55, 1'b0, 1'b0, 1'b0);
    check("full_count", rx_count0, 4);
    check("full_overflow", rx_overflow0, 1);
    check("full_head", rx_data0, 8'h11);
    send_byte(0, 8'h66, 1'b0, 1'b0, 1'b1);
    check("pushpop_count", rx_count0, 4);
    for (int k = 0; k < 4; k++) begin
      check("drain_data", rx_data0, exp_q[k]);
      rx_ready0 = 1'b1;
      tick(1);
      rx_ready0 = 1'b0;
    end
    check("drain_count", rx_count0, 0);
    rx_ready0 = 1'b1;
    tick(3);
    rx_ready0 = 1'b0;
    check("empty_pop_count", rx_count0, 0);
    check("overflow_sticky", rx_overflow0, 1);
    rst0 = 1'b1;
    tick(2);
    rst0 = 1'b0;
    tick(1);
    check("reset_overflow", rx_overflow0, 0);

    rst1 = 1'b0;
    tick(2);
    check("init_done_rst", init_done1, 0);
    check("init_ready_rst", cmd_ready1, 0);
    recv_cmd(1, 1'b0, b, p, s);
    check("init_byte1", b, 8'hF4);
    check("init_parity1", p, 0);
    tick(10);
    check("init_err", err1, 1);
    check("init_not_done", init_done1, 0);
    recv_cmd(1, 1'b1, b, p, s);
    check("init_byte2", b, 8'hF4);
    tick(10);
    check("init_done_pulse", done1, 1);
    check("init_done_flag", init_done1, 1);
    tick(300);
    check("init_ready_after", cmd_ready1, 1);
    check("init_no_early_ready", early_ready1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
